// File: rtl/autoenc_pkg.sv
// Constants and state encoding shared by the training-sequence controller,
// the autoencoder datapath and the testbench.
package autoenc_pkg;

    localparam int unsigned DATA_W   = 16;
    localparam int unsigned MARKER   = 342;
    localparam int unsigned MAX_ITER = 10000;

    typedef logic [2:0] train_seq_state_t;

    localparam train_seq_state_t ST_IDLE       = 3'd0;
    localparam train_seq_state_t ST_FETCH      = 3'd1;
    localparam train_seq_state_t ST_CAPT       = 3'd2;
    localparam train_seq_state_t ST_STREAM     = 3'd3;
    localparam train_seq_state_t ST_WAIT_TRAIN = 3'd4;
    localparam train_seq_state_t ST_DONE       = 3'd5;

    function automatic logic state_is_busy(input train_seq_state_t s);
        return (s != ST_IDLE) && (s != ST_DONE);
    endfunction

endpackage

// File: rtl/iter_counter.sv
// Saturating iteration counter with synchronous clear and a terminal-count
// flag that fires on the increment which reaches MAX_ITER.
module iter_counter #(
    parameter int unsigned CNT_W    = 14,
    parameter int unsigned MAX_ITER = 10000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear_i,
    input  logic             en_i,
    output logic [CNT_W-1:0] count_o,
    output logic             tc_o
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             at_max;

    assign at_max = (count_q == CNT_W'(MAX_ITER));

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (en_i && !at_max) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign tc_o    = en_i && !clear_i && (count_q == CNT_W'(MAX_ITER - 1));

endmodule

// File: rtl/train_seq_ctrl.sv
// Training-sequence controller: fetches sample words, streams them to the
// datapath, swallows the end-of-sample marker and counts completed updates.
module train_seq_ctrl #(
    parameter int unsigned DATA_W    = autoenc_pkg::DATA_W,
    parameter int unsigned ADDR_W    = 10,
    parameter int unsigned MEM_DEPTH = 1024,
    parameter int unsigned MARKER    = autoenc_pkg::MARKER,
    parameter int unsigned MAX_ITER  = autoenc_pkg::MAX_ITER,
    parameter int unsigned CNT_W     = 14
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd_en,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] s_data,
    output logic              s_valid,
    input  logic              s_ready,
    output logic              sample_end,
    input  logic              train_done,
    output logic [CNT_W-1:0]  iter_count,
    output logic              busy,
    output logic              done
);

    import autoenc_pkg::*;

    train_seq_state_t  state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] sdata_q, sdata_d;
    logic [ADDR_W-1:0] addr_next;
    logic              cnt_clr;
    logic              cnt_en;
    logic              cnt_tc;

    assign addr_next = (addr_q == ADDR_W'(MEM_DEPTH - 1)) ? '0 : addr_q + 1'b1;

    // abort is checked first in every busy state so in-flight read data and
    // same-cycle train_done/s_ready are dropped without side effects.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        sdata_d = sdata_q;
        cnt_clr = 1'b0;
        cnt_en  = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = ST_FETCH;
                    addr_d  = '0;
                    cnt_clr = 1'b1;
                end
            end
            ST_FETCH: begin
                state_d = abort ? ST_IDLE : ST_CAPT;
            end
            ST_CAPT: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (mem_rdata == DATA_W'(MARKER)) begin
                    state_d = ST_WAIT_TRAIN;
                end else begin
                    sdata_d = mem_rdata;
                    state_d = ST_STREAM;
                end
            end
            ST_STREAM: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (s_ready) begin
                    addr_d  = addr_next;
                    state_d = ST_FETCH;
                end
            end
            ST_WAIT_TRAIN: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (train_done) begin
                    cnt_en  = 1'b1;
                    addr_d  = addr_next;
                    state_d = cnt_tc ? ST_DONE : ST_FETCH;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            sdata_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            sdata_q <= sdata_d;
        end
    end

    iter_counter #(
        .CNT_W    (CNT_W),
        .MAX_ITER (MAX_ITER)
    ) u_iter_counter (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear_i (cnt_clr),
        .en_i    (cnt_en),
        .count_o (iter_count),
        .tc_o    (cnt_tc)
    );

    // Strobes are decoded from the registered state, so reset and abort clear them.
    assign mem_addr   = addr_q;
    assign mem_rd_en  = (state_q == ST_FETCH);
    assign s_data     = sdata_q;
    assign s_valid    = (state_q == ST_STREAM);
    assign sample_end = (state_q == ST_WAIT_TRAIN);
    assign busy       = state_is_busy(state_q);
    assign done       = (state_q == ST_DONE);

endmodule

// File: tb/tb_train_seq_ctrl.sv
// Directed testbench for train_seq_ctrl with a 1-cycle-latency sample memory
// model; MAX_ITER=3 and MEM_DEPTH=4 keep run-length and wrap cases short.
module tb_train_seq_ctrl;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned ADDR_W = 10;
    localparam int unsigned CNT_W  = 14;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic              abort;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd_en;
    logic [DATA_W-1:0] mem_rdata;
    logic [DATA_W-1:0] s_data;
    logic              s_valid;
    logic              s_ready;
    logic              sample_end;
    logic              train_done;
    logic [CNT_W-1:0]  iter_count;
    logic              busy;
    logic              done;

    logic [DATA_W-1:0] mem [0:1023];
    int unsigned       n_vec = 0;
    int unsigned       n_err = 0;
    int unsigned       xfers = 0;
    bit                marker_seen = 1'b0;

    train_seq_ctrl #(
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .MEM_DEPTH (4),
        .MARKER    (342),
        .MAX_ITER  (3),
        .CNT_W     (CNT_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .mem_addr   (mem_addr),
        .mem_rd_en  (mem_rd_en),
        .mem_rdata  (mem_rdata),
        .s_data     (s_data),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .sample_end (sample_end),
        .train_done (train_done),
        .iter_count (iter_count),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_rd_en) mem_rdata <= mem[mem_addr];
        if (s_valid && s_ready) xfers++;
        if (s_valid && s_data == 16'd342) marker_seen = 1'b1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic bit cond(input int which);
        case (which)
            0:       return mem_rd_en;
            1:       return s_valid;
            default: return sample_end;
        endcase
    endfunction

    task automatic wait_for(input int which, input string tag);
        int unsigned n = 0;
        bit hit = cond(which);
        while (!hit && n < 40) begin
            tick();
            n++;
            hit = cond(which);
        end
        check(tag, 32'(hit), 32'd1);
    endtask

    int unsigned base;
    logic [DATA_W-1:0] exp_data [3] = '{16'd9, 16'd8, 16'd9};
    logic [ADDR_W-1:0] exp_addr [3] = '{10'd0, 10'd2, 10'd0};

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = '0;
        mem_rdata  = '0;
        rst_n      = 1'b0;
        start      = 1'b0;
        abort      = 1'b0;
        s_ready    = 1'b0;
        train_done = 1'b0;
        tick();
        tick();
        check("rst_busy", 32'(busy), 0);
        check("rst_addr", 32'(mem_addr), 0);
        check("rst_iter", 32'(iter_count), 0);
        rst_n = 1'b1;

        // Stream {5,7,342} with backpressure on the first word
        mem[0] = 16'd5; mem[1] = 16'd7; mem[2] = 16'd342; mem[3] = 16'd342;
        base = xfers;
        start = 1'b1; tick(); start = 1'b0;
        check("fetch_rd_en", 32'(mem_rd_en), 1);
        check("fetch_addr", 32'(mem_addr), 0);
        check("fetch_busy", 32'(busy), 1);
        tick();
        check("capt_rd_en", 32'(mem_rd_en), 0);
        tick();
        check("lat_valid", 32'(s_valid), 1);
        check("word0", 32'(s_data), 5);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("bp_valid", 32'(s_valid), 1);
            check("bp_data", 32'(s_data), 5);
        end
        s_ready = 1'b1;
        tick();
        check("xfer_once", xfers - base, 1);
        check("post_xfer_valid", 32'(s_valid), 0);
        check("addr_adv", 32'(mem_addr), 1);
        tick(); tick();
        check("word1", 32'(s_data), 7);
        check("word1_valid", 32'(s_valid), 1);
        tick(); tick(); tick();
        check("marker_end", 32'(sample_end), 1);
        check("marker_no_valid", 32'(s_valid), 0);
        check("marker_not_sent", 32'(marker_seen), 0);
        check("xfer_total", xfers - base, 2);

        // start while busy is ignored
        start = 1'b1; tick(); start = 1'b0;
        check("busy_start_end", 32'(sample_end), 1);
        check("busy_start_addr", 32'(mem_addr), 2);
        tick();
        train_done = 1'b1; tick(); train_done = 1'b0;
        check("td_iter", 32'(iter_count), 1);
        check("td_addr", 32'(mem_addr), 3);
        check("td_end_clr", 32'(sample_end), 0);
        tick(); tick();
        check("marker2_end", 32'(sample_end), 1);

        // abort together with train_done
        abort = 1'b1; train_done = 1'b1; tick(); abort = 1'b0; train_done = 1'b0;
        check("abort_busy", 32'(busy), 0);
        check("abort_iter", 32'(iter_count), 1);
        check("abort_addr", 32'(mem_addr), 3);
        check("abort_end", 32'(sample_end), 0);
        abort = 1'b1; tick(); abort = 1'b0;
        check("idle_abort_iter", 32'(iter_count), 1);
        check("idle_abort_done", 32'(done), 0);

        // train_done during STREAM, then reset mid-stream
        s_ready = 1'b0;
        start = 1'b1; tick(); start = 1'b0;
        check("restart_iter", 32'(iter_count), 0);
        check("restart_addr", 32'(mem_addr), 0);
        tick(); tick();
        train_done = 1'b1; tick(); train_done = 1'b0;
        check("stream_td_iter", 32'(iter_count), 0);
        check("stream_td_valid", 32'(s_valid), 1);
        check("stream_td_data", 32'(s_data), 5);
        rst_n = 1'b0; tick(); tick();
        check("rst2_data", 32'(s_data), 0);
        check("rst2_valid", 32'(s_valid), 0);
        check("rst2_busy", 32'(busy), 0);
        check("rst2_rd_en", 32'(mem_rd_en), 0);
        rst_n = 1'b1;

        // Full run of 3 iterations with address wrap at MEM_DEPTH=4
        mem[0] = 16'd9; mem[1] = 16'd342; mem[2] = 16'd8; mem[3] = 16'd342;
        s_ready = 1'b1;
        start = 1'b1; tick(); start = 1'b0;
        for (int it = 0; it < 3; it++) begin
            wait_for(0, "run_fetch");
            check("run_first_addr", 32'(mem_addr), 32'(exp_addr[it]));
            wait_for(1, "run_valid");
            check("run_data", 32'(s_data), 32'(exp_data[it]));
            wait_for(2, "run_sample_end");
            tick();
            train_done = 1'b1; tick(); train_done = 1'b0;
            check("run_iter", 32'(iter_count), 32'(it + 1));
        end
        check("run_done", 32'(done), 1);
        check("run_busy", 32'(busy), 0);
        check("run_final_addr", 32'(mem_addr), 2);
        check("run_marker_not_sent", 32'(marker_seen), 0);
        tick(); tick();
        check("done_hold_iter", 32'(iter_count), 3);
        start = 1'b1; tick(); start = 1'b0;
        check("redo_iter", 32'(iter_count), 0);
        check("redo_busy", 32'(busy), 1);
        abort = 1'b1; tick(); abort = 1'b0;
        check("redo_abort_busy", 32'(busy), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
